// File: rtl/npu_ringsw_pkg.sv
// Shared types and helpers for the ring-switch loader.
//
// Contents:
//   state_e    loader FSM states (IDLE, SETUP, HIGH, DONE)
//   window_t   captured WL/BL enable window
//   MAX_LANES  number of physical CLKREG/DINSWREG lanes
//   ARG_W      width of the window argument fields
//   lane_len() shifts per lane for a given chain geometry
package npu_ringsw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_LANES = 4;
  localparam int ARG_W     = 9;

  typedef struct packed {
    logic [ARG_W-1:0] wl_start;
    logic [ARG_W-1:0] wl_end;
    logic [ARG_W-1:0] bl_start;
    logic [ARG_W-1:0] bl_end;
  } window_t;

  // The chain is split evenly across the lanes in use.
  function automatic int lane_len(input int num_wl, input int num_bl, input int parallel);
    int lanes;
    lanes = (parallel != 0) ? MAX_LANES : 1;
    return (num_wl + num_bl) / lanes;
  endfunction

endpackage

// File: rtl/ringsw_pattern_gen.sv
// Combinational enable-bit generator for one lane of the ring-switch chain.
//
// The chain holds NUM_WL word-line switches (indices 0..NUM_WL-1) followed by
// NUM_BL bit-line switches. A lane position maps to chain index
// k = lane + LANES*pos; the bit is 1 when k falls inside the WL window
// [wl_start, wl_end) or, for BL indices, when k-NUM_WL falls inside
// [bl_start, bl_end).
//
// Ports:
//   lane     lane number (0..LANES-1)
//   pos      position within the lane
//   win      enable window
//   bit_val  enable bit for (lane, pos)
module ringsw_pattern_gen
  import npu_ringsw_pkg::*;
#(
  parameter int NUM_WL = 256,
  parameter int NUM_BL = 256,
  parameter int LANES  = 4,
  parameter int POS_W  = 7
) (
  input  logic [1:0]       lane,
  input  logic [POS_W-1:0] pos,
  input  window_t          win,
  output logic             bit_val
);

  // One spare bit so the chain length itself is representable.
  localparam int K_W = $clog2(NUM_WL + NUM_BL) + 1;

  logic [K_W-1:0] k;
  logic [K_W-1:0] k_bl;

  always_comb begin
    k    = K_W'(lane) + K_W'(K_W'(LANES) * K_W'(pos));
    k_bl = k - K_W'(NUM_WL);
    if (k < K_W'(NUM_WL)) begin
      bit_val = (K_W'(win.wl_start) <= k) && (k < K_W'(win.wl_end));
    end else begin
      bit_val = (K_W'(win.bl_start) <= k_bl) && (k_bl < K_W'(win.bl_end));
    end
  end

endmodule

// File: rtl/ringsw_loader.sv
// Ring-switch select-chain loader.
//
// On an accepted start the WL/BL window is captured and a one-hot-window
// enable pattern is shifted serially into 1 or 4 lanes. Each shift is a SETUP
// phase (clock low, data presented) followed by a HIGH phase (clock high, data
// held), each CLK_DIV system clocks long. Position LANE_LEN-1 of each lane is
// shifted first, position 0 last. A one-cycle done pulse follows the final
// HIGH phase.
//
// Optional build macro RINGSW_CLEAR_EN: every accepted start first shifts a
// full all-zero pass through the chain, then the pattern pass.
//
// Handshake: start is a one-cycle request sampled only in IDLE. A start while
// busy is dropped silently. A start with a bad window (empty range or end past
// the chain) is refused and sets err, which stays set until the next accepted
// start. busy is high from the cycle after acceptance through the last HIGH
// cycle; done pulses for exactly one cycle after that.
//
// Ports:
//   clk, rstn             system clock, asynchronous active-low reset
//   start                 one-cycle load request
//   wl_start, wl_end      WL window [start, end)
//   bl_start, bl_end      BL window [start, end)
//   busy, done, err       status to the mode sequencer
//   clkreg, dinswreg      ring-switch shift clocks and serial data per lane
//   state_dbg             current FSM state
module ringsw_loader
  import npu_ringsw_pkg::*;
#(
  parameter int NUM_WL          = 256,
  parameter int NUM_BL          = 256,
  parameter int PARALLEL_RINGSW = 1,
  parameter int CLK_DIV         = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ARG_W-1:0]     wl_start,
  input  logic [ARG_W-1:0]     wl_end,
  input  logic [ARG_W-1:0]     bl_start,
  input  logic [ARG_W-1:0]     bl_end,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [MAX_LANES-1:0] clkreg,
  output logic [MAX_LANES-1:0] dinswreg,
  output state_e               state_dbg
);

  localparam int LANES    = (PARALLEL_RINGSW != 0) ? MAX_LANES : 1;
  localparam int LANE_LEN = lane_len(NUM_WL, NUM_BL, PARALLEL_RINGSW);
  localparam int POS_W    = (LANE_LEN > 1) ? $clog2(LANE_LEN) : 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LIM_W    = ARG_W + 1;

  localparam logic [MAX_LANES-1:0] LANE_MASK = MAX_LANES'((1 << LANES) - 1);
  localparam logic [POS_W-1:0]     LAST_J    = POS_W'(LANE_LEN - 1);
  localparam logic [DIV_W-1:0]     LAST_DIV  = DIV_W'(CLK_DIV - 1);
  localparam logic [LIM_W-1:0]     WL_LIMIT  = LIM_W'(NUM_WL);
  localparam logic [LIM_W-1:0]     BL_LIMIT  = LIM_W'(NUM_BL);

`ifdef RINGSW_CLEAR_EN
  localparam logic CLEAR_FIRST = 1'b1;
`else
  localparam logic CLEAR_FIRST = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [POS_W-1:0]       j_q, j_d;
  logic                   clear_q, clear_d;
  window_t                win_q, win_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [MAX_LANES-1:0]   clkreg_q, clkreg_d;
  logic [MAX_LANES-1:0]   din_q, din_d;

  logic                   args_bad;
  logic                   accept;
  logic [POS_W-1:0]       pos_d;
  logic [MAX_LANES-1:0]   pat_bits;

  // Argument validation on the live inputs; only meaningful in IDLE.
  always_comb begin
    args_bad = (wl_start >= wl_end) || (bl_start >= bl_end) ||
               ({1'b0, wl_end} > WL_LIMIT) || ({1'b0, bl_end} > BL_LIMIT);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    j_d     = j_q;
    clear_d = clear_q;
    accept  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (args_bad) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            err_d   = 1'b0;
            state_d = SETUP;
            div_d   = '0;
            j_d     = '0;
            clear_d = CLEAR_FIRST;
          end
        end
      end
      SETUP: begin
        if (div_q == LAST_DIV) begin
          state_d = HIGH;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == LAST_DIV) begin
          div_d = '0;
          if (j_q != LAST_J) begin
            j_d     = j_q + 1'b1;
            state_d = SETUP;
          end else if (clear_q) begin
            // Zero pass finished: restart the shift count for the pattern.
            clear_d = 1'b0;
            j_d     = '0;
            state_d = SETUP;
          end else begin
            state_d = DONE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The pattern for the cycle being entered: on the accept edge the window
  // register is not loaded yet, so the generators see the live inputs.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d = '{wl_start: wl_start, wl_end: wl_end, bl_start: bl_start, bl_end: bl_end};
    end
    pos_d = LAST_J - j_d;
  end

  for (genvar l = 0; l < MAX_LANES; l++) begin : g_lane
    if (l < LANES) begin : g_act
      ringsw_pattern_gen #(
        .NUM_WL (NUM_WL),
        .NUM_BL (NUM_BL),
        .LANES  (LANES),
        .POS_W  (POS_W)
      ) u_gen (
        .lane    (2'(l)),
        .pos     (pos_d),
        .win     (win_d),
        .bit_val (pat_bits[l])
      );
    end else begin : g_off
      assign pat_bits[l] = 1'b0;
    end
  end

  // Outputs are registered from the next state so the shift clocks are
  // glitch-free; data changes only on entry to SETUP, together with the
  // falling clock edge, and is held through HIGH.
  always_comb begin
    busy_d   = (state_d == SETUP) || (state_d == HIGH);
    done_d   = (state_d == DONE);
    clkreg_d = (state_d == HIGH) ? LANE_MASK : '0;
    unique case (state_d)
      SETUP:   din_d = clear_d ? '0 : (pat_bits & LANE_MASK);
      HIGH:    din_d = din_q;
      default: din_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      div_q    <= '0;
      j_q      <= '0;
      clear_q  <= 1'b0;
      win_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clkreg_q <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      j_q      <= j_d;
      clear_q  <= clear_d;
      win_q    <= win_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clkreg_q <= clkreg_d;
      din_q    <= din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign clkreg    = clkreg_q;
  assign dinswreg  = din_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ringsw_loader.sv
// Testbench for ringsw_loader: a 4-lane CLK_DIV=2 instance (a_*) and a
// single-lane CLK_DIV=1 instance (s_*). Shifted data is captured on each
// clkreg rising edge and compared with a chain model built from the window
// rules; done latency, busy/done shape, lane masking and data stability are
// checked per load.
module tb_ringsw_loader;
  import npu_ringsw_pkg::*;

  localparam int NUM_WL = 256;
  localparam int NUM_BL = 256;
  localparam int A_LANES = 4;
  localparam int A_DIV   = 2;
  localparam int A_LEN   = (NUM_WL + NUM_BL) / A_LANES;
  localparam int S_LANES = 1;
  localparam int S_DIV   = 1;
  localparam int S_LEN   = NUM_WL + NUM_BL;
`ifdef RINGSW_CLEAR_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int A_DONE = PASSES * 2 * A_DIV * A_LEN;
  localparam int S_DONE = PASSES * 2 * S_DIV * S_LEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0;
  logic       s_start = 1'b0;
  logic [8:0] wl_start = '0, wl_end = '0, bl_start = '0, bl_end = '0;

  logic       a_busy, a_done, a_err, s_busy, s_done, s_err;
  logic [3:0] a_clkreg, a_dinswreg, s_clkreg, s_dinswreg;
  state_e     a_state, s_state;

  ringsw_loader #(.NUM_WL(NUM_WL), .NUM_BL(NUM_BL), .PARALLEL_RINGSW(1), .CLK_DIV(A_DIV)) dut (
    .clk(clk), .rstn(rstn), .start(a_start),
    .wl_start(wl_start), .wl_end(wl_end), .bl_start(bl_start), .bl_end(bl_end),
    .busy(a_busy), .done(a_done), .err(a_err),
    .clkreg(a_clkreg), .dinswreg(a_dinswreg), .state_dbg(a_state)
  );

  ringsw_loader #(.NUM_WL(NUM_WL), .NUM_BL(NUM_BL), .PARALLEL_RINGSW(0), .CLK_DIV(S_DIV)) dut_s (
    .clk(clk), .rstn(rstn), .start(s_start),
    .wl_start(wl_start), .wl_end(wl_end), .bl_start(bl_start), .bl_end(bl_end),
    .busy(s_busy), .done(s_done), .err(s_err),
    .clkreg(s_clkreg), .dinswreg(s_dinswreg), .state_dbg(s_state)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  // Expected per-shift lane vectors: optional all-zero pass, then shift j
  // carries lane position len-1-j, chain index k = lane + lanes*pos.
  task automatic build_exp(input int lanes, input int len, input int wls, input int wle,
                           input int bls, input int ble);
    logic [3:0] v;
    int pos, k;
    exp_q.delete();
    for (int p = 1; p < PASSES; p++)
      for (int j = 0; j < len; j++) exp_q.push_back(4'h0);
    for (int j = 0; j < len; j++) begin
      v = 4'h0;
      pos = len - 1 - j;
      for (int l = 0; l < lanes; l++) begin
        k = l + lanes * pos;
        if (k < NUM_WL) v[l] = (k >= wls) && (k < wle);
        else            v[l] = (k - NUM_WL >= bls) && (k - NUM_WL < ble);
      end
      exp_q.push_back(v);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic fire(input bit sel, input int wls, input int wle, input int bls, input int ble);
    @(negedge clk);
    wl_start = 9'(wls); wl_end = 9'(wle); bl_start = 9'(bls); bl_end = 9'(ble);
    if (sel) s_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    s_start = 1'b0;
  endtask

  // Samples one load cycle by cycle starting at the current negedge (the
  // first cycle after acceptance). Collects the data seen at each clkreg
  // rise and counts protocol violations. poke_a/poke_b inject extra starts
  // (with scrambled window inputs) into the 4-lane instance.
  task automatic collect(input bit sel, input int budget, input int poke_a, input int poke_b,
                         output int done_at, output int proto_bad);
    logic [3:0] c, d, pc, pd, mask;
    logic b, dn;
    int age, div;
    mask = sel ? 4'h1 : 4'hF;
    div = sel ? S_DIV : A_DIV;
    got_q.delete();
    done_at = -1; proto_bad = 0; pc = '0; pd = '0; age = 0;
    for (int i = 0; i <= budget; i++) begin
      if (i > 0) @(negedge clk);
      if (i == poke_a) begin
        a_start = 1'b1; wl_start = 9'd7; wl_end = 9'd3; bl_start = 9'd0; bl_end = 9'd300;
      end else if (i == poke_b) begin
        a_start = 1'b1; wl_start = 9'd100; wl_end = 9'd200; bl_start = 9'd50; bl_end = 9'd60;
      end else begin
        a_start = 1'b0;
      end
      c  = sel ? s_clkreg : a_clkreg;
      d  = sel ? s_dinswreg : a_dinswreg;
      b  = sel ? s_busy : a_busy;
      dn = sel ? s_done : a_done;
      if (d == pd) age++; else age = 0;
      if (((c | d) & ~mask) != 4'h0) proto_bad++;
      if (c != 4'h0 && pc == 4'h0) begin
        got_q.push_back(d);
        if (c != mask) proto_bad++;
        if (age < div) proto_bad++;
      end
      if (c != 4'h0 && pc != 4'h0 && d != pd) proto_bad++;
      if (dn) begin
        if (b || c != 4'h0 || d != 4'h0) proto_bad++;
        done_at = i;
        break;
      end
      if (!b) proto_bad++;
      pc = c;
      pd = d;
    end
    a_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({a_busy, a_done, a_err, a_clkreg, a_dinswreg} !== 11'h0 || a_state !== IDLE) begin
      errors++;
      $display("FAIL reset_a: busy=%b done=%b err=%b clkreg=%h din=%h state=%0d, required all 0 and IDLE",
               a_busy, a_done, a_err, a_clkreg, a_dinswreg, a_state);
    end
    checks++;
    if ({s_busy, s_done, s_err, s_clkreg, s_dinswreg} !== 11'h0 || s_state !== IDLE) begin
      errors++;
      $display("FAIL reset_s: busy=%b done=%b err=%b clkreg=%h din=%h state=%0d, required all 0 and IDLE",
               s_busy, s_done, s_err, s_clkreg, s_dinswreg, s_state);
    end
  endtask

  // One 4-lane load: stream, done latency, protocol, done width.
  task automatic run_a(input string name, input int wls, input int wle, input int bls, input int ble,
                       input int poke_a, input int poke_b);
    int done_at, proto_bad, fd;
    build_exp(A_LANES, A_LEN, wls, wle, bls, ble);
    fire(1'b0, wls, wle, bls, ble);
    collect(1'b0, A_DONE + 40, poke_a, poke_b, done_at, proto_bad);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      errors++;
      $display("FAIL %s_stream: first wrong shift %0d, got %0d shifts, required %0d shifts matching model",
               name, fd, got_q.size(), exp_q.size());
    end
    checks++;
    if (done_at != A_DONE) begin
      errors++;
      $display("FAIL %s_done_at: done at T+1+%0d, required T+1+%0d", name, done_at, A_DONE);
    end
    checks++;
    if (proto_bad != 0) begin
      errors++;
      $display("FAIL %s_protocol: %0d busy/lane/stability violations, required 0", name, proto_bad);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b err=%b, required 0 0 0", name, a_done, a_busy, a_err);
    end
  endtask

  task automatic test_window_parallel();
    run_a("win", 0, 32, 0, 10, -1, -1);
  endtask

  task automatic test_bad_args();
    int wls, bls, bad_cycles;
    int bad_set[3][4];
    bad_set[0] = '{9, 300, 0, 10};
    bad_set[1] = '{0, 20, 40, 40};
    bad_set[2] = '{0, 20, 10, 257};
    fire(1'b0, 5, 5, 0, 10);
    checks++;
    if (a_err !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_err: err=%b busy=%b, required err=1 busy=0", a_err, a_busy);
    end
    bad_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_clkreg !== 4'h0 || a_busy !== 1'b0 || a_done !== 1'b0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL bad_idle: %0d cycles with clkreg/busy/done active, required 0", bad_cycles);
    end
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_sticky: err=%b, required 1", a_err);
    end
    for (int t = 0; t < 3; t++) begin
      fire(1'b0, bad_set[t][0], bad_set[t][1], bad_set[t][2], bad_set[t][3]);
      @(negedge clk);
      checks++;
      if (a_err !== 1'b1 || a_busy !== 1'b0 || a_clkreg !== 4'h0) begin
        errors++;
        $display("FAIL bad_case%0d: err=%b busy=%b clkreg=%h, required 1 0 0", t, a_err, a_busy, a_clkreg);
      end
    end
    // A valid start clears the error as it is accepted.
    wls = $urandom_range(0, 200);
    bls = $urandom_range(0, 200);
    fire(1'b0, wls, wls + 1, bls, 256);
    checks++;
    if (a_err !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_clear: err=%b busy=%b, required err=0 busy=1", a_err, a_busy);
    end
    repeat (A_DONE + 2) @(negedge clk);
  endtask

  task automatic test_serial();
    int done_at, proto_bad, fd;
    build_exp(S_LANES, S_LEN, 0, 1, 255, 256);
    fire(1'b1, 0, 1, 255, 256);
    collect(1'b1, S_DONE + 40, -1, -1, done_at, proto_bad);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      errors++;
      $display("FAIL serial_stream: first wrong shift %0d, got %0d shifts, required %0d", fd, got_q.size(), exp_q.size());
    end
    checks++;
    if (done_at != S_DONE) begin
      errors++;
      $display("FAIL serial_done_at: done at T+1+%0d, required T+1+%0d", done_at, S_DONE);
    end
    checks++;
    if (proto_bad != 0) begin
      errors++;
      $display("FAIL serial_protocol: %0d violations, required 0", proto_bad);
    end
  endtask

  task automatic test_random();
    int wls, wle, bls, ble;
    run_a("full", 0, 256, 0, 256, -1, -1);
    for (int n = 0; n < 3; n++) begin
      wls = $urandom_range(0, 255);
      wle = $urandom_range(wls + 1, 256);
      bls = $urandom_range(0, 255);
      ble = $urandom_range(bls + 1, 256);
      run_a($sformatf("rnd%0d", n), wls, wle, bls, ble, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    run_a("busy_start", 16, 48, 128, 192, 9, 199);
  endtask

  task automatic test_reset_mid();
    int wls, bls;
    fire(1'b0, 0, 256, 0, 256);
    repeat (99) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_err, a_clkreg, a_dinswreg} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b err=%b clkreg=%h din=%h, required all 0",
               a_busy, a_done, a_err, a_clkreg, a_dinswreg);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wls = $urandom_range(0, 250);
    bls = $urandom_range(0, 250);
    run_a("post_reset", wls, wls + 5, bls, bls + 6, -1, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_window_parallel();
    test_bad_args();
    test_serial();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
